// File: rtl/vx_tcu_drl_align_acc.sv
// Tensor-core accumulate front end: aligns TCK product lanes plus the C addend
// to a shared exponent (S1), then sums them into one signed accumulator (S2).
module vx_tcu_drl_align_acc #(
  parameter int TCK   = 4,
  parameter int SIG_W = 25,
  parameter int EXP_W = 10,
  parameter int ACC_W = 32,
  parameter int EXC_W = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      valid_in,
  output logic                      ready_in,
  input  logic [31:0]               req_id_in,
  input  logic [EXP_W-1:0]          max_exp,
  input  logic [TCK:0][7:0]         shift_amt,
  input  logic [TCK:0][SIG_W-1:0]   raw_sigs,
  input  logic [EXC_W-1:0]          exceptions_in,
  input  logic [TCK-1:0]            lane_mask,
  output logic                      valid_out,
  input  logic                      ready_out,
  output logic [31:0]               req_id_out,
  output logic [EXP_W-1:0]          exp_out,
  output logic signed [ACC_W-1:0]   sum_out,
  output logic                      sticky_out,
  output logic                      zero_out,
  output logic [EXC_W-1:0]          exceptions_out
);

  typedef struct packed {
    logic [31:0]             id;
    logic [EXP_W-1:0]        exp;
    logic [EXC_W-1:0]        exc;
    logic                    sticky;
    logic [TCK:0][ACC_W-1:0] lanes;
  } s1_t;

  typedef struct packed {
    logic [31:0]      id;
    logic [EXP_W-1:0] exp;
    logic [EXC_W-1:0] exc;
    logic             sticky;
    logic             zero;
    logic [ACC_W-1:0] sum;
  } s2_t;

  logic s1_valid_q, s2_valid_q;
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  logic s2_adv;

  logic [TCK:0]            en;
  logic [TCK:0][ACC_W-1:0] ext;
  logic [TCK:0][ACC_W-1:0] lost;
  logic [TCK:0][ACC_W-1:0] aln;
  logic [ACC_W-1:0]        sum;

  assign s2_adv   = !s2_valid_q || ready_out;
  assign ready_in = !s1_valid_q || s2_adv;
  assign en       = {1'b1, lane_mask};

  // Lane value = sign-extended significand with 3 guard bits below it.
  always_comb begin
    s1_d        = '0;
    s1_d.id     = req_id_in;
    s1_d.exp    = max_exp;
    s1_d.exc    = exceptions_in;
    ext         = '0;
    lost        = '0;
    aln         = '0;
    for (int i = 0; i <= TCK; i++) begin
      ext[i] = {{(ACC_W-SIG_W-3){raw_sigs[i][SIG_W-1]}},
                raw_sigs[i], 3'b000};
      if ({24'd0, shift_amt[i]} >= 32'(ACC_W)) begin
        aln[i]  = {ACC_W{ext[i][ACC_W-1]}};
        lost[i] = ext[i];
      end else begin
        aln[i]  = $signed(ext[i]) >>> shift_amt[i];
        lost[i] = ext[i] & ~({ACC_W{1'b1}} << shift_amt[i]);
      end
      if (en[i]) begin
        s1_d.lanes[i] = aln[i];
        s1_d.sticky   = s1_d.sticky | (|lost[i]);
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i <= TCK; i++) begin
      sum = sum + s1_q.lanes[i];
    end
    s2_d.id     = s1_q.id;
    s2_d.exp    = s1_q.exp;
    s2_d.exc    = s1_q.exc;
    s2_d.sticky = s1_q.sticky;
    s2_d.sum    = sum;
    s2_d.zero   = (sum == '0) && !s1_q.sticky;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      if (ready_in) s1_valid_q <= valid_in;
      if (valid_in && ready_in) s1_q <= s1_d;
      if (s2_adv) s2_valid_q <= s1_valid_q;
      if (s1_valid_q && s2_adv) s2_q <= s2_d;
    end
  end

  assign valid_out      = s2_valid_q;
  assign req_id_out     = s2_q.id;
  assign exp_out        = s2_q.exp;
  assign sum_out        = s2_q.sum;
  assign sticky_out     = s2_q.sticky;
  assign zero_out       = s2_q.zero;
  assign exceptions_out = s2_q.exc;

endmodule
